// File: rtl/spart_tx_if.sv
// Bus-side handshake of the SPART transmitter: driver write strobe/data
// plus the status and serial outputs that the transmitter returns.
interface spart_tx_if #(
   parameter int DATA_BITS = 8
);
   logic                 iocs;
   logic                 iorw;
   logic [1:0]           ioaddr;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tbr;
   logic                 txd;
   logic                 shift;
   logic                 busy;

   modport master (
      output iocs, iorw, ioaddr, tx_data,
      input  tbr, txd, shift, busy
   );

   modport slave (
      input  iocs, iorw, ioaddr, tx_data,
      output tbr, txd, shift, busy
   );
endinterface

// File: rtl/spart_tx.sv
// SPART transmitter: one-deep holding buffer feeding an 8N1 shifter that
// advances one bit every OVERSAMPLE baud ticks; back-to-back frames are gapless.
module spart_tx #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      enable,
   spart_tx_if.slave bus
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        tick_q, tick_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] buf_q, buf_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 full_q, full_d;
   logic                 tbr_q, tbr_d;
   logic                 txd_q, txd_d;
   logic                 shift_q, shift_d;
   logic                 busy_q, busy_d;
   logic                 wr_accept;
   logic                 bit_done;

   // tbr_q is only ever the registered inverse of full_q, so gating on it
   // keeps a write from ever landing on the same edge as a buffer transfer.
   assign wr_accept = bus.iocs && !bus.iorw && (bus.ioaddr == 2'b00) && tbr_q;
   assign bit_done  = enable && (tick_q == CW'(OVERSAMPLE - 1));

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      shreg_d = shreg_q;
      full_d  = full_q;
      txd_d   = txd_q;
      shift_d = 1'b0;
      busy_d  = busy_q;

      if (state_q != S_IDLE && enable) begin
         tick_d = tick_q + CW'(1);
      end

      case (state_q)
         S_IDLE: begin
            tick_d = '0;
            idx_d  = '0;
            if (full_q) begin
               shreg_d = buf_q;
               full_d  = 1'b0;
               state_d = S_START;
               txd_d   = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_START: begin
            if (bit_done) begin
               state_d = S_DATA;
               tick_d  = '0;
               idx_d   = '0;
               txd_d   = shreg_q[0];
               shift_d = 1'b1;
            end
         end
         S_DATA: begin
            if (bit_done) begin
               tick_d  = '0;
               shift_d = 1'b1;
               if (idx_q == IW'(DATA_BITS - 1)) begin
                  state_d = S_STOP;
                  txd_d   = 1'b1;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  shreg_d = shreg_q >> 1;
                  txd_d   = shreg_d[0];
               end
            end
         end
         S_STOP: begin
            if (bit_done) begin
               tick_d  = '0;
               shift_d = 1'b1;
               // Chain straight into the next start bit when a byte is waiting.
               if (full_q) begin
                  shreg_d = buf_q;
                  full_d  = 1'b0;
                  state_d = S_START;
                  txd_d   = 1'b0;
               end else begin
                  state_d = S_IDLE;
                  txd_d   = 1'b1;
                  busy_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (wr_accept) begin
         buf_d  = bus.tx_data;
         full_d = 1'b1;
      end
      tbr_d = ~full_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         idx_q   <= '0;
         buf_q   <= '0;
         shreg_q <= '0;
         full_q  <= 1'b0;
         tbr_q   <= 1'b1;
         txd_q   <= 1'b1;
         shift_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         shreg_q <= shreg_d;
         full_q  <= full_d;
         tbr_q   <= tbr_d;
         txd_q   <= txd_d;
         shift_q <= shift_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.tbr   = tbr_q;
   assign bus.txd   = txd_q;
   assign bus.shift = shift_q;
   assign bus.busy  = busy_q;
endmodule

// File: tb/tb_spart_tx.sv
// Directed bench for spart_tx: frame shape, buffering, pacing, reset and a
// behavioural 8N1 receiver on txd.
module tb_spart_tx;
   logic clk;
   logic rst;
   logic enable;
   int   n_total = 0;
   int   n_pass  = 0;
   int   en_div  = 1;
   int   en_cnt  = 0;

   spart_tx_if #(.DATA_BITS(8)) bus ();

   spart_tx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance one clock, sample 1 time unit later, then set enable for the next edge.
   task automatic step();
      @(posedge clk);
      #1;
      en_cnt = (en_cnt + 1) % en_div;
      enable = (en_cnt == 0);
   endtask

   // Bus access from idle; realigns the enable phase so a tick lands on the transfer edge.
   task automatic host_access(input logic [7:0] b, input logic [1:0] addr, input logic rw);
      bus.iocs    = 1'b1;
      bus.iorw    = rw;
      bus.ioaddr  = addr;
      bus.tx_data = b;
      en_cnt      = en_div - 1;
      step();
      bus.iocs    = 1'b0;
      bus.iorw    = 1'b1;
      bus.ioaddr  = 2'b00;
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return b[k-1];
   endfunction

   // Starts at the sample showing the start bit, ends at the sample just after the stop bit.
   task automatic check_frame(input string tag, input logic [7:0] b, input int p,
                              input int wc1, input logic [7:0] wb1,
                              input int wc2, input logic [7:0] wb2);
      int txd_err = 0;
      int busy_err = 0;
      int sh_cnt = 0;
      int sh_bad = 0;
      for (int c = 0; c < 10 * p; c++) begin
         if (bus.txd !== frame_bit(b, c / p)) txd_err++;
         if (bus.busy !== 1'b1) busy_err++;
         if (c > 0 && bus.shift === 1'b1) begin
            sh_cnt++;
            if (c % p != 0) sh_bad++;
         end
         if ((wc1 >= 0 && c == wc1 + 1) || (wc2 >= 0 && c == wc2 + 1))
            chk({tag, "_tbr_after_wr"}, 32'(bus.tbr), 32'd0);
         if (c == wc1 || c == wc2) begin
            bus.iocs    = 1'b1;
            bus.iorw    = 1'b0;
            bus.ioaddr  = 2'b00;
            bus.tx_data = (c == wc1) ? wb1 : wb2;
         end
         step();
         bus.iocs = 1'b0;
         bus.iorw = 1'b1;
      end
      if (bus.shift === 1'b1) sh_cnt++;
      chk({tag, "_txd_bits"}, 32'(txd_err), 32'd0);
      chk({tag, "_busy"}, 32'(busy_err), 32'd0);
      chk({tag, "_shift_cnt"}, 32'(sh_cnt), 32'd10);
      chk({tag, "_shift_pos"}, 32'(sh_bad), 32'd0);
   endtask

   initial begin
      logic [7:0] rx;
      logic       start_ok;
      logic       stop_bit;
      int         idle_err;
      int         sh_cnt;
      int         waited;

      rst         = 1'b1;
      enable      = 1'b1;
      bus.iocs    = 1'b0;
      bus.iorw    = 1'b1;
      bus.ioaddr  = 2'b00;
      bus.tx_data = 8'h00;
      repeat (3) step();
      chk("rst_txd", 32'(bus.txd), 32'd1);
      chk("rst_tbr", 32'(bus.tbr), 32'd1);
      chk("rst_shift", 32'(bus.shift), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      repeat (2) step();

      // Single frame, tick every clock.
      host_access(8'h48, 2'b00, 1'b0);
      chk("w48_tbr_fall", 32'(bus.tbr), 32'd0);
      step();
      chk("w48_tbr_rise", 32'(bus.tbr), 32'd1);
      chk("w48_txd_start", 32'(bus.txd), 32'd0);
      chk("w48_busy", 32'(bus.busy), 32'd1);
      check_frame("f48", 8'h48, 16, -1, 8'h00, -1, 8'h00);
      chk("f48_end_txd", 32'(bus.txd), 32'd1);
      chk("f48_end_busy", 32'(bus.busy), 32'd0);
      $display("txn: single frame 8'h48 done");

      // Reads and other addresses are not writes.
      host_access(8'h77, 2'b00, 1'b1);
      chk("read_tbr", 32'(bus.tbr), 32'd1);
      host_access(8'h77, 2'b01, 1'b0);
      chk("addr1_tbr", 32'(bus.tbr), 32'd1);
      repeat (3) step();
      chk("nowrite_busy", 32'(bus.busy), 32'd0);
      chk("nowrite_txd", 32'(bus.txd), 32'd1);
      $display("txn: read / non-zero address ignored");

      // Back-to-back frames, plus a write while the buffer is full.
      host_access(8'h55, 2'b00, 1'b0);
      chk("w55_tbr_fall", 32'(bus.tbr), 32'd0);
      step();
      check_frame("f55", 8'h55, 16, 0, 8'hAA, 20, 8'h11);
      check_frame("fAA", 8'hAA, 16, -1, 8'h00, -1, 8'h00);
      chk("fAA_end_txd", 32'(bus.txd), 32'd1);
      chk("fAA_end_busy", 32'(bus.busy), 32'd0);
      chk("fAA_end_tbr", 32'(bus.tbr), 32'd1);
      idle_err = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (bus.txd !== 1'b1 || bus.busy !== 1'b0) idle_err++;
      end
      chk("no_frame_11", 32'(idle_err), 32'd0);
      $display("txn: back-to-back 8'h55/8'hAA, write of 8'h11 dropped");

      // Tick one clock in four.
      en_div = 4;
      host_access(8'hFF, 2'b00, 1'b0);
      chk("wFF_tbr_fall", 32'(bus.tbr), 32'd0);
      step();
      chk("wFF_txd_start", 32'(bus.txd), 32'd0);
      check_frame("fFF", 8'hFF, 64, -1, 8'h00, -1, 8'h00);
      chk("fFF_end_txd", 32'(bus.txd), 32'd1);
      chk("fFF_end_busy", 32'(bus.busy), 32'd0);
      en_div = 1;
      en_cnt = 0;
      enable = 1'b1;
      $display("txn: slow-tick frame 8'hFF done");

      // Asynchronous reset in the middle of data bit 3.
      host_access(8'hA5, 2'b00, 1'b0);
      step();
      repeat (70) step();
      chk("wA5_bit3", 32'(bus.txd), 32'd0);
      chk("wA5_busy", 32'(bus.busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_txd", 32'(bus.txd), 32'd1);
      chk("mid_rst_tbr", 32'(bus.tbr), 32'd1);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      sh_cnt = 0;
      idle_err = 0;
      repeat (3) begin
         step();
         if (bus.shift === 1'b1) sh_cnt++;
      end
      rst = 1'b0;
      repeat (30) begin
         step();
         if (bus.shift === 1'b1) sh_cnt++;
         if (bus.txd !== 1'b1 || bus.busy !== 1'b0) idle_err++;
      end
      chk("post_rst_shift", 32'(sh_cnt), 32'd0);
      chk("post_rst_idle", 32'(idle_err), 32'd0);
      host_access(8'h0F, 2'b00, 1'b0);
      chk("w0F_tbr_fall", 32'(bus.tbr), 32'd0);
      step();
      check_frame("f0F", 8'h0F, 16, -1, 8'h00, -1, 8'h00);
      chk("f0F_end_busy", 32'(bus.busy), 32'd0);
      $display("txn: reset mid-frame, then 8'h0F sent");

      // Behavioural 8N1 receiver sampling mid-bit on txd.
      host_access(8'h48, 2'b00, 1'b0);
      waited = 0;
      while (bus.txd !== 1'b0 && waited < 50) begin
         step();
         waited++;
      end
      chk("rx_start_seen", 32'(waited < 50), 32'd1);
      repeat (8) step();
      start_ok = (bus.txd === 1'b0);
      rx = 8'h00;
      for (int i = 0; i < 8; i++) begin
         repeat (16) step();
         rx[i] = bus.txd;
      end
      repeat (16) step();
      stop_bit = bus.txd;
      chk("rx_rda", 32'(start_ok && stop_bit === 1'b1), 32'd1);
      chk("rx_byte", 32'(rx), 32'h48);
      waited = 0;
      while (bus.busy !== 1'b0 && waited < 50) begin
         step();
         waited++;
      end
      chk("rx_tx_idle", 32'(bus.busy), 32'd0);
      $display("txn: loopback received %02h", rx);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
